mem_stage_lsu: RTL and testbench

MEM_STAGE_LSU -- requirements
Module: mem_stage_lsu

---
 rtl/mem_stage_lsu.sv | 144 ++++++++++++++
 tb/tb_mem_stage_lsu.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/mem_stage_lsu.sv
// mem_stage_lsu -- MEM pipeline stage load/store unit.
//
// Issues one data-memory request per aligned load/store, holds the pipeline
// (stall) until the memory acknowledges or a timeout expires, and produces
// the MEM/WB pipeline register. Misaligned accesses are dropped with a
// one-cycle misalign pulse; timeouts produce a one-cycle bus_err pulse.
//
// Ports:
//   clk, rst                     clock, synchronous active-low reset
//   RegWrite/MemRead/MemWrite/
//   MemToReg, alu_out, rt_data,
//   rd                           EX/MEM pipeline register contents
//   stall                        combinational hold request to upstream
//   dmem_req/we/addr/wdata       registered data-memory request
//   dmem_ack, dmem_rdata         memory completion strobe and load data
//   wb_*                         MEM/WB pipeline register
//   misalign, bus_err            one-cycle error pulses
//
// state | meaning
// IDLE  | no access outstanding; MEM/WB follows EX/MEM each cycle
// WAIT  | request outstanding; waiting for dmem_ack or timeout
module mem_stage_lsu #(
  parameter int TIMEOUT = 15
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        RegWrite,
  input  logic        MemRead,
  input  logic        MemWrite,
  input  logic        MemToReg,
  input  logic [31:0] alu_out,
  input  logic [31:0] rt_data,
  input  logic [4:0]  rd,
  output logic        stall,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [31:0] dmem_addr,
  output logic [31:0] dmem_wdata,
  input  logic        dmem_ack,
  input  logic [31:0] dmem_rdata,
  output logic        wb_RegWrite,
  output logic        wb_MemToReg,
  output logic [31:0] wb_read_data,
  output logic [31:0] wb_alu_out,
  output logic [4:0]  wb_rd,
  output logic        misalign,
  output logic        bus_err
);

  typedef enum logic {IDLE = 1'b0, WAIT = 1'b1} state_t;

  localparam logic [3:0] TO_CNT = 4'(TIMEOUT);

  state_t     state, state_nxt;
  logic [3:0] wait_cnt;
  logic       memop, aligned, timeout_hit;

  assign memop       = MemRead | MemWrite;
  assign aligned     = (alu_out[1:0] == 2'b00);
  // An ack arriving in the limit cycle takes priority over the abort.
  assign timeout_hit = (state == WAIT) && (wait_cnt == TO_CNT) && !dmem_ack;

  // Gated by rst so a flushed pipeline never sees a stale hold.
  assign stall = rst & (((state == IDLE) & memop & aligned) |
                        ((state == WAIT) & ~dmem_ack & ~timeout_hit));

  always_ff @(posedge clk) begin
    if (!rst) state <= IDLE;
    else      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (memop && aligned)          state_nxt = WAIT;
      WAIT: if (dmem_ack || timeout_hit)   state_nxt = IDLE;
      default:                             state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      wait_cnt <= '0;
    end else if (state == IDLE) begin
      wait_cnt <= '0;
    end else if (!dmem_ack) begin
      wait_cnt <= wait_cnt + 4'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      dmem_req     <= 1'b0;
      dmem_we      <= 1'b0;
      dmem_addr    <= '0;
      dmem_wdata   <= '0;
      wb_RegWrite  <= 1'b0;
      wb_MemToReg  <= 1'b0;
      wb_read_data <= '0;
      wb_alu_out   <= '0;
      wb_rd        <= '0;
      misalign     <= 1'b0;
      bus_err      <= 1'b0;
    end else begin
      misalign <= 1'b0;
      bus_err  <= 1'b0;
      case (state)
        IDLE: begin
          if (memop && aligned) begin
            // Issue; MEM/WB gets a bubble while the access is in flight.
            dmem_req    <= 1'b1;
            dmem_we     <= MemWrite;
            dmem_addr   <= alu_out;
            dmem_wdata  <= rt_data;
            wb_RegWrite <= 1'b0;
          end else begin
            misalign    <= memop;
            wb_RegWrite <= RegWrite & ~memop;
            wb_MemToReg <= MemToReg;
            wb_alu_out  <= alu_out;
            wb_rd       <= rd;
          end
        end
        WAIT: begin
          if (dmem_ack) begin
            dmem_req    <= 1'b0;
            wb_RegWrite <= RegWrite;
            wb_MemToReg <= MemToReg;
            wb_alu_out  <= alu_out;
            wb_rd       <= rd;
            // MemRead together with MemWrite is a store: no load data.
            if (MemRead && !MemWrite) wb_read_data <= dmem_rdata;
          end else if (timeout_hit) begin
            dmem_req    <= 1'b0;
            bus_err     <= 1'b1;
            wb_RegWrite <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_stage_lsu.sv
module tb_mem_stage_lsu;

  localparam int TIMEOUT = 15;

  logic        clk = 1'b0;
  logic        rst;
  logic        RegWrite, MemRead, MemWrite, MemToReg;
  logic [31:0] alu_out, rt_data;
  logic [4:0]  rd;
  logic        stall, dmem_req, dmem_we;
  logic [31:0] dmem_addr, dmem_wdata;
  logic        dmem_ack;
  logic [31:0] dmem_rdata;
  logic        wb_RegWrite, wb_MemToReg;
  logic [31:0] wb_read_data, wb_alu_out;
  logic [4:0]  wb_rd;
  logic        misalign, bus_err;

  mem_stage_lsu #(.TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst(rst),
    .RegWrite(RegWrite), .MemRead(MemRead), .MemWrite(MemWrite), .MemToReg(MemToReg),
    .alu_out(alu_out), .rt_data(rt_data), .rd(rd),
    .stall(stall),
    .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata),
    .dmem_ack(dmem_ack), .dmem_rdata(dmem_rdata),
    .wb_RegWrite(wb_RegWrite), .wb_MemToReg(wb_MemToReg),
    .wb_read_data(wb_read_data), .wb_alu_out(wb_alu_out), .wb_rd(wb_rd),
    .misalign(misalign), .bus_err(bus_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        rw, mr, mw, mtr, ack;
    logic [31:0] alu, wdata, rdata;
    logic [4:0]  rd;
    logic        e_stall, e_mis, e_rw, e_full;
  } vec_t;

  typedef struct {
    logic        rw, mtr, mis, full, berr;
    logic [31:0] alu, rdata;
    logic [4:0]  rd;
    int          stall_n;
  } exp_t;

  exp_t        sb[$];
  vec_t        vecs[6];
  int          checks = 0;
  int          errors = 0;
  logic [31:0] exp_rdata = 32'h0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive_nop();
    RegWrite = 0; MemRead = 0; MemWrite = 0; MemToReg = 0;
    alu_out = 0; rt_data = 0; rd = 0; dmem_ack = 0; dmem_rdata = 0;
  endtask

  // Called at posedge+1; returns at the next posedge+1.
  task automatic apply_vec(input vec_t v, input string tag);
    exp_t e;
    RegWrite = v.rw; MemRead = v.mr; MemWrite = v.mw; MemToReg = v.mtr;
    alu_out = v.alu; rt_data = v.wdata; rd = v.rd;
    dmem_ack = v.ack; dmem_rdata = v.rdata;
    #1;
    chk({tag, " stall"}, stall, v.e_stall);
    e.rw = v.e_rw; e.mtr = v.mtr; e.mis = v.e_mis; e.full = v.e_full; e.berr = 0;
    e.alu = v.alu; e.rdata = exp_rdata; e.rd = v.rd; e.stall_n = 0;
    sb.push_back(e);
    @(posedge clk); #1;
    e = sb.pop_front();
    chk({tag, " wb_RegWrite"}, wb_RegWrite, e.rw);
    chk({tag, " misalign"}, misalign, e.mis);
    chk({tag, " dmem_req"}, dmem_req, 0);
    chk({tag, " wb_read_data"}, wb_read_data, e.rdata);
    if (e.full) begin
      chk({tag, " wb_alu_out"}, wb_alu_out, e.alu);
      chk({tag, " wb_rd"}, wb_rd, e.rd);
      chk({tag, " wb_MemToReg"}, wb_MemToReg, e.mtr);
    end
    dmem_ack = 0;
  endtask

  // ack_at = WAIT cycle (1-based) carrying dmem_ack; 0 means never ack.
  task automatic do_access(input logic rw, input logic mr, input logic mw, input logic mtr,
                           input logic [31:0] addr, input logic [31:0] wdata,
                           input logic [4:0] rdv, input int ack_at,
                           input logic [31:0] rdata, input string tag);
    exp_t e;
    int   n_stall = 0;
    bit   done = 0;
    bit   stable = 1;
    e.rw = (ack_at > 0) ? rw : 1'b0;
    e.rdata = (ack_at > 0 && mr && !mw) ? rdata : exp_rdata;
    e.alu = addr; e.rd = rdv; e.mtr = mtr; e.mis = 0;
    e.full = (ack_at > 0); e.berr = (ack_at == 0);
    e.stall_n = (ack_at > 0) ? ack_at : TIMEOUT + 1;
    sb.push_back(e);
    RegWrite = rw; MemRead = mr; MemWrite = mw; MemToReg = mtr;
    alu_out = addr; rt_data = wdata; rd = rdv;
    for (int c = 0; c < 40 && !done; c++) begin
      dmem_ack   = (ack_at > 0 && c == ack_at);
      dmem_rdata = dmem_ack ? rdata : 32'h0BAD_F00D;
      @(negedge clk);
      if (c > 0 && !(dmem_req === 1'b1 && dmem_addr === addr &&
                     dmem_wdata === wdata && dmem_we === mw)) stable = 0;
      if (c == 1) chk({tag, " bubble wb_RegWrite"}, wb_RegWrite, 0);
      if (stall) n_stall++;
      else done = 1;
      @(posedge clk); #1;
    end
    drive_nop();
    chk({tag, " completed within budget"}, done, 1);
    @(negedge clk);
    e = sb.pop_front();
    chk({tag, " stall cycles"}, n_stall, e.stall_n);
    chk({tag, " request stable"}, stable, 1);
    chk({tag, " dmem_req dropped"}, dmem_req, 0);
    chk({tag, " bus_err"}, bus_err, e.berr);
    chk({tag, " wb_RegWrite"}, wb_RegWrite, e.rw);
    chk({tag, " wb_read_data"}, wb_read_data, e.rdata);
    if (e.full) begin
      chk({tag, " wb_alu_out"}, wb_alu_out, e.alu);
      chk({tag, " wb_rd"}, wb_rd, e.rd);
    end
    exp_rdata = e.rdata;
    @(posedge clk); #1;
    chk({tag, " bus_err one pulse"}, bus_err, 0);
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, " stall"}, stall, 0);
    chk({tag, " dmem_req"}, dmem_req, 0);
    chk({tag, " dmem_we"}, dmem_we, 0);
    chk({tag, " dmem_addr"}, dmem_addr, 0);
    chk({tag, " dmem_wdata"}, dmem_wdata, 0);
    chk({tag, " wb_RegWrite"}, wb_RegWrite, 0);
    chk({tag, " wb_MemToReg"}, wb_MemToReg, 0);
    chk({tag, " wb_read_data"}, wb_read_data, 0);
    chk({tag, " wb_alu_out"}, wb_alu_out, 0);
    chk({tag, " wb_rd"}, wb_rd, 0);
    chk({tag, " misalign"}, misalign, 0);
    chk({tag, " bus_err"}, bus_err, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    //           rw mr mw mtr ack alu            wdata          rdata          rd | stall mis rw full
    vecs[0] = '{1, 0, 0, 0, 0, 32'h0000_1234, 32'h0,         32'h0,         5'd5,  0, 0, 1, 1};
    vecs[1] = '{0, 0, 0, 1, 0, 32'hFFFF_FFFF, 32'h0,         32'h0,         5'd31, 0, 0, 0, 1};
    vecs[2] = '{1, 1, 0, 1, 0, 32'h0000_0103, 32'h0,         32'h0,         5'd9,  0, 1, 0, 0};
    vecs[3] = '{1, 0, 0, 0, 0, 32'h0000_0008, 32'h0,         32'h0,         5'd1,  0, 0, 1, 1};
    vecs[4] = '{0, 0, 1, 0, 0, 32'h0000_0202, 32'h1234_5678, 32'h0,         5'd0,  0, 1, 0, 0};
    vecs[5] = '{1, 0, 0, 0, 1, 32'h0000_0055, 32'h0,         32'h1111_1111, 5'd3,  0, 0, 1, 1};

    // Reset with non-zero, non-memory inputs: registers must still clear.
    rst = 0;
    drive_nop();
    RegWrite = 1; alu_out = 32'hFFFF_FFFC; rd = 5'd31; rt_data = 32'hFFFF_FFFF;
    repeat (2) @(posedge clk);
    #1;
    drive_nop();
    @(negedge clk);
    chk_all_zero("reset");
    @(posedge clk); #1;
    rst = 1;

    for (int i = 0; i < 6; i++) apply_vec(vecs[i], $sformatf("vec%0d", i));

    do_access(1, 1, 0, 1, 32'h0000_0100, 32'h0,         5'd7,  3,  32'hDEAD_BEEF, "load ack3");
    apply_vec(vecs[0], "alu after load");
    do_access(0, 0, 1, 0, 32'h0000_0200, 32'hA5A5_A5A5, 5'd0,  1,  32'h0,         "store ack1");
    do_access(0, 1, 1, 0, 32'h0000_0300, 32'h5A5A_0F0F, 5'd2,  2,  32'h7777_7777, "rd+wr as store");
    apply_vec(vecs[0], "alu before timeout");
    do_access(1, 1, 0, 1, 32'h0000_0400, 32'h0,         5'd4,  0,  32'h0,         "load timeout");
    do_access(1, 1, 0, 1, 32'h0000_0404, 32'h0,         5'd6,  TIMEOUT + 1, 32'hCAFE_F00D, "load ack at limit");

    // Reset during the second WAIT cycle of a load.
    RegWrite = 1; MemRead = 1; MemToReg = 1; alu_out = 32'h0000_0500; rd = 5'd8;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 0;
    drive_nop();
    @(posedge clk); #1;
    rst = 1;
    @(negedge clk);
    chk_all_zero("reset mid-wait");
    @(posedge clk); #1;
    exp_rdata = 32'h0;
    apply_vec(vecs[3], "alu after reset");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
